// File: rtl/fp32_pkg.sv
// fp32_pkg: shared binary32 field widths, special encodings, flag
// indices, packed {sign, exp, frac} view and a 24-bit leading-zero count.
package fp32_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Returns 24 for an all-zero input.
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       hit;
        n   = 5'd0;
        hit = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!hit) begin
                if (v[i]) hit = 1'b1;
                else      n   = n + 5'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp32_round.sv
// fp32_round: round-to-nearest-even packer for a normalised product.
// Ports: i_sign, i_exp (signed biased exponent), i_mant {m[23:0],G,R,S};
//        o_res (packed binary32), o_ovf, o_unf, o_inx.
module fp32_round
    import fp32_pkg::*;
(
    input  logic              i_sign,
    input  logic signed [9:0] i_exp,
    input  logic [26:0]       i_mant,
    output fp32_t             o_res,
    output logic              o_ovf,
    output logic              o_unf,
    output logic              o_inx
);

    logic              w_tiny;
    logic signed [9:0] w_amt_raw;
    logic [4:0]        w_amt;
    logic [26:0]       w_mask;
    logic [26:0]       w_sh;
    logic [23:0]       w_m;
    logic              w_g;
    logic              w_r;
    logic              w_s;
    logic              w_up;
    logic [24:0]       w_sum;
    logic signed [9:0] w_exp_r;
    logic              w_grs;

    // Tininess is judged on the exponent before rounding.
    assign w_tiny    = (i_exp <= 10'sd0);
    assign w_amt_raw = 10'sd1 - i_exp;

    // Past 26 every significant bit is already in sticky.
    assign w_amt = !w_tiny              ? 5'd0  :
                   (w_amt_raw > 10'sd26) ? 5'd26 :
                   w_amt_raw[4:0];

    assign w_mask = ~(27'h7FF_FFFF << w_amt);
    assign w_sh   = i_mant >> w_amt;

    assign w_m = w_sh[26:3];
    assign w_g = w_sh[2];
    assign w_r = w_sh[1];
    assign w_s = w_sh[0] | (|(i_mant & w_mask));

    assign w_up  = w_g & (w_r | w_s | w_m[0]);
    assign w_sum = {1'b0, w_m} + {24'd0, w_up};

    assign w_exp_r = i_exp + $signed({9'd0, w_sum[24]});
    assign w_grs   = w_g | w_r | w_s;

    assign o_ovf = ~w_tiny & (w_exp_r >= 10'sd255);
    assign o_inx = w_grs | o_ovf;
    assign o_unf = w_tiny & o_inx;

    always_comb begin
        o_res      = '0;
        o_res.sign = i_sign;
        if (o_ovf) begin
            o_res.exp  = 8'hFF;
            o_res.frac = '0;
        end else if (w_tiny) begin
            // Rounding out of the top subnormal lands on exp field 1.
            o_res.exp  = {7'd0, w_sum[23]};
            o_res.frac = w_sum[22:0];
        end else begin
            o_res.exp  = w_exp_r[7:0];
            o_res.frac = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
        end
    end

endmodule

// File: rtl/fp32_multi.sv
// fp32_multi: combinational binary32 multiplier with sticky exception flags.
// Ports: clk, reset (sync, active-high), a, b -> op (a*b), flags
//        {invalid, overflow, underflow, inexact}, sticky_flags (registered).
module fp32_multi
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] op,
    output logic [3:0]  flags,
    output logic [3:0]  sticky_flags
);

    logic              w_sign;
    logic [7:0]        w_ea;
    logic [7:0]        w_eb;
    logic [22:0]       w_fa;
    logic [22:0]       w_fb;
    logic              w_a_nan;
    logic              w_b_nan;
    logic              w_a_snan;
    logic              w_b_snan;
    logic              w_a_inf;
    logic              w_b_inf;
    logic              w_a_zero;
    logic              w_b_zero;
    logic [23:0]       w_ma_raw;
    logic [23:0]       w_mb_raw;
    logic [4:0]        w_lza;
    logic [4:0]        w_lzb;
    logic [23:0]       w_ma;
    logic [23:0]       w_mb;
    logic signed [9:0] w_exa;
    logic signed [9:0] w_exb;
    logic [47:0]       w_prod;
    logic signed [9:0] w_exp;
    logic [26:0]       w_rmant;
    fp32_t             w_rres;
    logic              w_rovf;
    logic              w_runf;
    logic              w_rinx;
    logic [31:0]       w_op;
    logic [3:0]        w_flags;
    logic [3:0]        r_sticky;

    assign w_sign = a[31] ^ b[31];
    assign w_ea   = a[30:23];
    assign w_eb   = b[30:23];
    assign w_fa   = a[22:0];
    assign w_fb   = b[22:0];

    assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
    assign w_a_snan = w_a_nan & ~w_fa[22];
    assign w_b_snan = w_b_nan & ~w_fb[22];
    assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
    assign w_a_zero = (w_ea == 8'h00) && (w_fa == 23'd0);
    assign w_b_zero = (w_eb == 8'h00) && (w_fb == 23'd0);

    // Hidden bit only for normals; subnormals are left-justified here
    // so the product always lies in [2^46, 2^48).
    assign w_ma_raw = {|w_ea, w_fa};
    assign w_mb_raw = {|w_eb, w_fb};
    assign w_lza    = lzc24(w_ma_raw);
    assign w_lzb    = lzc24(w_mb_raw);
    assign w_ma     = w_ma_raw << w_lza;
    assign w_mb     = w_mb_raw << w_lzb;

    assign w_exa = $signed({2'b00, (w_ea == 8'd0) ? 8'd1 : w_ea})
                 - $signed({5'd0, w_lza});
    assign w_exb = $signed({2'b00, (w_eb == 8'd0) ? 8'd1 : w_eb})
                 - $signed({5'd0, w_lzb});

    assign w_prod = {24'd0, w_ma} * {24'd0, w_mb};

    assign w_exp = w_exa + w_exb - 10'(BIAS)
                 + $signed({9'd0, w_prod[47]});

    assign w_rmant = w_prod[47]
        ? {w_prod[47:24], w_prod[23], w_prod[22], |w_prod[21:0]}
        : {w_prod[46:23], w_prod[22], w_prod[21], |w_prod[20:0]};

    fp32_round u_round (
        .i_sign (w_sign),
        .i_exp  (w_exp),
        .i_mant (w_rmant),
        .o_res  (w_rres),
        .o_ovf  (w_rovf),
        .o_unf  (w_runf),
        .o_inx  (w_rinx)
    );

    always_comb begin
        w_op    = w_rres;
        w_flags = 4'd0;
        if (w_a_nan || w_b_nan) begin
            w_op                  = QNAN;
            w_flags[FLAG_INVALID] = w_a_snan | w_b_snan;
        end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
            w_op                  = QNAN;
            w_flags[FLAG_INVALID] = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            w_op = {w_sign, POS_INF[30:0]};
        end else if (w_a_zero || w_b_zero) begin
            w_op = {w_sign, 31'd0};
        end else begin
            w_flags[FLAG_OVERFLOW]  = w_rovf;
            w_flags[FLAG_UNDERFLOW] = w_runf;
            w_flags[FLAG_INEXACT]   = w_rinx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_sticky <= 4'd0;
        else       r_sticky <= r_sticky | w_flags;
    end

    assign op           = w_op;
    assign flags        = w_flags;
    assign sticky_flags = r_sticky;

endmodule

// File: tb/tb_fp32_multi.sv
// tb_fp32_multi: directed-vector self-checking bench for fp32_multi.
// Each scenario task drives a, b / reset and compares against constants.
module tb_fp32_multi;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    wire  [31:0] op;
    wire  [3:0]  flags;
    wire  [3:0]  sticky_flags;

    int nchecks = 0;
    int nerr    = 0;

    fp32_multi dut (
        .clk          (clk),
        .reset        (reset),
        .a            (a),
        .b            (b),
        .op           (op),
        .flags        (flags),
        .sticky_flags (sticky_flags)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        nchecks++;
        if (sticky_flags !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_sticky got=%b exp=0000", sticky_flags);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] ve [4];
        logic [3:0]  vf [4];
        va = '{32'h3FC00000, 32'h3F800000, 32'hC0000000, 32'h40000000};
        vb = '{32'h40000000, 32'hBF800000, 32'hC0400000, 32'h3FC00000};
        ve = '{32'h40400000, 32'hBF800000, 32'h40C00000, 32'h40400000};
        vf = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            a = va[i];
            b = vb[i];
            #1;
            nchecks++;
            if (op !== ve[i]) begin
                nerr++;
                $display("FAIL basic_op[%0d] got=%h exp=%h", i, op, ve[i]);
            end
            nchecks++;
            if (flags !== vf[i]) begin
                nerr++;
                $display("FAIL basic_flags[%0d] got=%b exp=%b", i, flags, vf[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] va [2];
        logic [31:0] vb [2];
        logic [31:0] ve [2];
        logic [3:0]  vf [2];
        // second vector is an exact tie resolved upward to even
        va = '{32'h3F800001, 32'h4B000001};
        vb = '{32'h3F800001, 32'h40400000};
        ve = '{32'h3F800002, 32'h4BC00002};
        vf = '{4'b0001, 4'b0001};
        for (int i = 0; i < 2; i++) begin
            a = va[i];
            b = vb[i];
            #1;
            nchecks++;
            if (op !== ve[i]) begin
                nerr++;
                $display("FAIL round_op[%0d] got=%h exp=%h", i, op, ve[i]);
            end
            nchecks++;
            if (flags !== vf[i]) begin
                nerr++;
                $display("FAIL round_flags[%0d] got=%b exp=%b", i, flags, vf[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [31:0] ve [7];
        logic [3:0]  vf [7];
        va = '{32'h7F800000, 32'h00000000, 32'hFF800000, 32'h80000000,
               32'h7FA00000, 32'h7FC00001, 32'hFF800000};
        vb = '{32'h00000000, 32'hFF800000, 32'h40000000, 32'h3F800000,
               32'h3F800000, 32'h3F800000, 32'hFF800000};
        ve = '{32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000,
               32'h7FC00000, 32'h7FC00000, 32'h7F800000};
        vf = '{4'b1000, 4'b1000, 4'b0000, 4'b0000,
               4'b1000, 4'b0000, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            a = va[i];
            b = vb[i];
            #1;
            nchecks++;
            if (op !== ve[i]) begin
                nerr++;
                $display("FAIL special_op[%0d] got=%h exp=%h", i, op, ve[i]);
            end
            nchecks++;
            if (flags !== vf[i]) begin
                nerr++;
                $display("FAIL special_flags[%0d] got=%b exp=%b", i, flags, vf[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] va [2];
        logic [31:0] ve [2];
        va = '{32'h7F7FFFFF, 32'hFF7FFFFF};
        ve = '{32'h7F800000, 32'hFF800000};
        for (int i = 0; i < 2; i++) begin
            a = va[i];
            b = 32'h40000000;
            #1;
            nchecks++;
            if (op !== ve[i]) begin
                nerr++;
                $display("FAIL ovf_op[%0d] got=%h exp=%h", i, op, ve[i]);
            end
            nchecks++;
            if (flags !== 4'b0101) begin
                nerr++;
                $display("FAIL ovf_flags[%0d] got=%b exp=0101", i, flags);
            end
        end
    endtask

    task automatic test_subnormal();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [31:0] ve [5];
        logic [3:0]  vf [5];
        va = '{32'h00800000, 32'h00000001, 32'h007FFFFF,
               32'h00000001, 32'h80000001};
        vb = '{32'h3F000000, 32'h3F000000, 32'h3F800001,
               32'h4B000000, 32'h3F800000};
        ve = '{32'h00400000, 32'h00000000, 32'h00800000,
               32'h00800000, 32'h80000001};
        vf = '{4'b0000, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            a = va[i];
            b = vb[i];
            #1;
            nchecks++;
            if (op !== ve[i]) begin
                nerr++;
                $display("FAIL subn_op[%0d] got=%h exp=%h", i, op, ve[i]);
            end
            nchecks++;
            if (flags !== vf[i]) begin
                nerr++;
                $display("FAIL subn_flags[%0d] got=%b exp=%b", i, flags, vf[i]);
            end
        end
    endtask

    task automatic test_sticky();
        @(negedge clk);
        reset = 1'b1;
        a     = 32'h3FC00000;
        b     = 32'h40000000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        a     = 32'h7F7FFFFF;
        b     = 32'h40000000;
        @(posedge clk);
        #1;
        a = 32'h3FC00000;
        b = 32'h40000000;
        @(posedge clk);
        #1;
        nchecks++;
        if (sticky_flags !== 4'b0101) begin
            nerr++;
            $display("FAIL sticky_hold got=%b exp=0101", sticky_flags);
        end
        // reset wins over a flagging operation on the same edge
        a     = 32'h7F7FFFFF;
        reset = 1'b1;
        @(posedge clk);
        #1;
        nchecks++;
        if (sticky_flags !== 4'b0000) begin
            nerr++;
            $display("FAIL sticky_reset got=%b exp=0000", sticky_flags);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        nchecks++;
        if (sticky_flags !== 4'b0101) begin
            nerr++;
            $display("FAIL sticky_reaccum got=%b exp=0101", sticky_flags);
        end
        a = 32'h7F800000;
        b = 32'h00000000;
        @(posedge clk);
        #1;
        nchecks++;
        if (sticky_flags !== 4'b1101) begin
            nerr++;
            $display("FAIL sticky_or got=%b exp=1101", sticky_flags);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_overflow();
        test_subnormal();
        test_sticky();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
